// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding and the latency counter width.
// Also provides the word-index width derived from the array depth.
package dmem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Latency counter width; wide enough for LATENCY up to 15
  localparam int CNT_W = 4;

  // Number of address bits needed to select one word out of depth words
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array, DEPTH x N, no reset.
// Latency: read data appears in the output register one edge after rd_en.
// Backpressure: none; the caller never asserts rd_en and wr_en together.
module dmem_array #(
  parameter int N     = 32,
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [N-1:0]     wdata,
  output logic [N-1:0]     rdata
);

  logic [N-1:0] mem [DEPTH];

  // Write the selected word, or capture its pre-edge contents for a read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wdata;
    end
    if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store handshake.
// Latency: valid pulses LATENCY cycles after acceptance (one per request).
// Backpressure: mem_ready drops while an access is in flight; initiator holds proc_req.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int N       = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_req,
  input  logic         we,
  input  logic [31:0]  addr,
  input  logic [N-1:0] wdata,
  output logic         mem_ready,
  output logic         valid,
  output logic [N-1:0] rdata,
  output logic         err
);

  localparam int IDX_W = idx_width(DEPTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             err_pending;
  logic             resp_we;

  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     arr_rdata;

  // mem_ready depends on registered state only, so there is no path from proc_req
  assign mem_ready = (state != BUSY);
  assign accept    = proc_req & mem_ready;

  // Range check on the full address: anything at or past DEPTH words is rejected,
  // with no wrap-around onto low words
  assign in_range  = ((addr >> (IDX_W + 2)) == 32'd0);
  assign idx       = addr[IDX_W+1:2];

  dmem_array #(
    .N     (N),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .wr_en (accept & we & in_range),
    .rd_en (accept & ~we & in_range),
    .idx   (idx),
    .wdata (wdata),
    .rdata (arr_rdata)
  );

  // The array output register holds the captured word; it is only exposed while
  // the response for an in-range read is being presented, otherwise rdata is 0
  assign rdata = (valid && !resp_we && !err) ? arr_rdata : '0;

  // Request acceptance, latency countdown and one-cycle response pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      valid       <= 1'b0;
      err         <= 1'b0;
      err_pending <= 1'b0;
      resp_we     <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          valid <= 1'b0;
          err   <= 1'b0;
          if (accept) begin
            resp_we     <= we;
            err_pending <= ~in_range;
            if (LATENCY > 1) begin
              state <= BUSY;
              cnt   <= CNT_W'(LATENCY - 1);
            end else begin
              state <= RESP;
              valid <= 1'b1;
              err   <= ~in_range;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
            valid <= 1'b1;
            err   <= err_pending;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with DEPTH=1024, LATENCY=2.
// Responses are collected by a monitor and matched in order against expectations.
// Acceptance and response cycles are timestamped to check latency and throughput.
module tb_dmem_responder;

  localparam int N       = 32;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic         clk;
  logic         rst;
  logic         proc_req;
  logic         we;
  logic [31:0]  addr;
  logic [N-1:0] wdata;
  logic         mem_ready;
  logic         valid;
  logic [N-1:0] rdata;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] rsp_dat_q[$];
  logic        rsp_err_q[$];
  int          rsp_cyc_q[$];
  int          acc_q[$];

  dmem_responder #(
    .N       (N),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .proc_req  (proc_req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .mem_ready (mem_ready),
    .valid     (valid),
    .rdata     (rdata),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every response pulse with the edge count it followed
  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) begin
      rsp_dat_q.push_back(rdata);
      rsp_err_q.push_back(err);
      rsp_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request and hold it until accepted; returns just after the accept edge
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int acc);
    bit ok;
    ok = 1'b0;
    proc_req = 1'b1;
    we       = w;
    addr     = a;
    wdata    = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      proc_req = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      acc_q.push_back(cyc);
    end
  endtask

  task automatic idle();
    proc_req = 1'b0;
    we       = 1'b0;
  endtask

  // Pop the oldest response and compare data, error flag and latency
  task automatic check_resp(input string tag, input logic [31:0] exp_d, input logic exp_e);
    bit got;
    int a;
    int c;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_cyc_q.size() > 0) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got || acc_q.size() == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      a = acc_q.pop_front();
      c = rsp_cyc_q.pop_front();
      chk({tag, "_rdata"}, rsp_dat_q.pop_front(), exp_d);
      chk({tag, "_err"}, {31'd0, rsp_err_q.pop_front()}, {31'd0, exp_e});
      chk({tag, "_lat"}, c - a, LATENCY - 1);
    end
  endtask

  initial begin
    int a0, a1, a2, tmp;
    rst      = 1'b1;
    proc_req = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;

    // Reset state
    #1;
    chk("rst_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle for five cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("idle_ready", {31'd0, mem_ready}, 32'd1);
      chk("idle_valid", {31'd0, valid}, 32'd0);
      chk("idle_rdata", rdata, 32'd0);
      chk("idle_err", {31'd0, err}, 32'd0);
    end

    // Basic write then read, mem_ready low while busy
    send(1'b1, 32'h10, 32'hDEADBEEF, tmp);
    idle();
    chk("busy_ready", {31'd0, mem_ready}, 32'd0);
    chk("busy_valid", {31'd0, valid}, 32'd0);
    check_resp("wr10", 32'd0, 1'b0);
    send(1'b0, 32'h10, 32'd0, tmp);
    idle();
    chk("busy_ready_rd", {31'd0, mem_ready}, 32'd0);
    check_resp("rd10", 32'hDEADBEEF, 1'b0);

    // Back-to-back reads of pre-written words
    send(1'b1, 32'h0, 32'd1, tmp); idle(); check_resp("pw0", 32'd0, 1'b0);
    send(1'b1, 32'h4, 32'd2, tmp); idle(); check_resp("pw4", 32'd0, 1'b0);
    send(1'b1, 32'h8, 32'd3, tmp); idle(); check_resp("pw8", 32'd0, 1'b0);
    send(1'b0, 32'h0, 32'd0, a0);
    send(1'b0, 32'h4, 32'd0, a1);
    send(1'b0, 32'h8, 32'd0, a2);
    idle();
    chk("b2b_gap01", a1 - a0, LATENCY);
    chk("b2b_gap12", a2 - a1, LATENCY);
    check_resp("b2b0", 32'd1, 1'b0);
    check_resp("b2b1", 32'd2, 1'b0);
    check_resp("b2b2", 32'd3, 1'b0);

    // Out of range accesses, no aliasing onto word 0
    send(1'b1, 32'h0, 32'd7, tmp); idle(); check_resp("w0_7", 32'd0, 1'b0);
    send(1'b1, 32'h1000, 32'h55, tmp); idle(); check_resp("oor_wr", 32'd0, 1'b1);
    send(1'b0, 32'h1000, 32'd0, tmp); idle(); check_resp("oor_rd", 32'd0, 1'b1);
    send(1'b0, 32'h0, 32'd0, tmp); idle(); check_resp("noalias", 32'd7, 1'b0);
    send(1'b0, 32'h80000000, 32'd0, tmp); idle(); check_resp("oor_hi", 32'd0, 1'b1);
    send(1'b0, 32'h0, 32'd0, tmp); idle(); check_resp("noalias2", 32'd7, 1'b0);
    // Last in-range word
    send(1'b1, 32'hFFC, 32'h1234, tmp); idle(); check_resp("wtop", 32'd0, 1'b0);
    send(1'b0, 32'hFFF, 32'd0, tmp); idle(); check_resp("rtop", 32'h1234, 1'b0);

    // Misaligned read ignores low address bits
    send(1'b1, 32'h10, 32'hA5A5, tmp); idle(); check_resp("wA5", 32'd0, 1'b0);
    send(1'b0, 32'h13, 32'd0, tmp); idle(); check_resp("mis13", 32'hA5A5, 1'b0);

    // Reset during BUSY discards the pending read, array contents survive
    send(1'b1, 32'h20, 32'hCAFE, tmp); idle(); check_resp("w20", 32'd0, 1'b0);
    send(1'b0, 32'h20, 32'd0, tmp);
    idle();
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, mem_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    void'(acc_q.pop_back());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_resp", rsp_cyc_q.size(), 32'd0);
    send(1'b0, 32'h20, 32'd0, tmp); idle(); check_resp("r20", 32'hCAFE, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("no_stray_resp", rsp_cyc_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory side of the load/store handshake driven by the MEM-stage load/store unit.
- Accepts `proc_req`/`we`/`addr`/`wdata` and stores words in an internal array.
- Returns `mem_ready`/`valid`/`rdata` after a configurable access latency.
- Used as the data memory in the core top level and as the memory model in pipeline benches.

Parameters:
- N, 32, data word width in bits.
- DEPTH, 1024, number of N-bit words; power of two, >= 2.
- LATENCY, 2, cycles from request acceptance to the `valid` pulse; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- proc_req  input  1  request from initiator; held with `we`/`addr`/`wdata` until accepted.
- we  input  1  1 = write, 0 = read.
- addr  input  32  byte address; bits [1:0] ignored (word access only).
- wdata  input  N  write data.
- mem_ready  output  1  responder can accept a request this cycle.
- valid  output  1  one-cycle completion pulse for every accepted request, read or write.
- rdata  output  N  read data; meaningful only while `valid`=1 for a read, else 0.
- err  output  1  asserted together with `valid` when the request address was out of range.

Behaviour:
- Reset (asynchronous, any time including mid-access):
  - state=IDLE, mem_ready=1, valid=0, rdata=0, err=0, latency counter=0.
  - Pending request is discarded, no response is produced.
  - Array contents are not reset.
- Acceptance: a request is accepted on a rising edge where proc_req=1 and mem_ready=1. At that edge:
  - Address in range (addr < DEPTH*4): a write updates word addr[$clog2(DEPTH)+1:2]; a read captures that word's current (pre-edge) contents into the response register.
  - Out of range: the write is dropped and the read captures 0; err_pending=1.
  - `we` is latched for the response.
- States:
  - IDLE: mem_ready=1, valid=0. On accept: go to BUSY with cnt=LATENCY-1 if LATENCY>1; else go to RESP.
  - BUSY: mem_ready=0, valid=0. cnt decrements each cycle; at cnt=1 go to RESP. proc_req is ignored and the initiator keeps holding it.
  - RESP: valid=1 for exactly one cycle; rdata=captured word for a read, 0 for a write; err=err_pending. mem_ready=1.
    - Accept in this cycle: go to BUSY/RESP as from IDLE (back-to-back).
    - No accept: go to IDLE.
- Timing:
  - Accept at edge k gives valid high during the cycle following edge k+LATENCY-1.
  - Sustained throughput is one request per LATENCY cycles.
- Outputs valid, rdata and err are registered. mem_ready is a decode of registered state only, with no combinational path from proc_req.
- Ordering: requests complete strictly in acceptance order. A read accepted after a write to the same word returns the new data.
- Out-of-range check uses the full 32-bit address; no wrap-around aliasing.
- Reads of never-written in-range words return X in simulation; benches must not depend on them.

Decomposition:
- Shared package `dmem_pkg`:
  - State enum (IDLE, BUSY, RESP).
  - Latency counter width constant (4 bits).
  - Function computing the word-index width from DEPTH.
- One sub-module `dmem_array`: single-port synchronous word array (DEPTH x N), write-enable and registered read-out, no reset. The responder instantiates it and keeps FSM, counter, range check and response registers at top level.

Test Plan:
- Reset, then idle for 5 cycles -> mem_ready=1, valid=0, rdata=0, err=0 throughout.
- LATENCY=2: write addr=0x10 wdata=0xDEADBEEF, then read addr=0x10 -> for each request, valid is high 2 cycles after acceptance; read rdata=0xDEADBEEF, err=0; write completion shows rdata=0; mem_ready is low during BUSY.
- Back-to-back: proc_req held high for reads to 0x0, 0x4, 0x8, pre-written 1, 2, 3 -> three valid pulses, 2 cycles apart, rdata 1, 2, 3 in order; each new request is accepted in the RESP cycle of the previous one.
- Out of range, DEPTH=1024: write addr=0x1000 wdata=0x55, then read 0x1000, then read 0x0 (holding 7) -> first two responses have err=1 and the read returns 0; third returns 7 with err=0, so no aliasing.
- Misaligned read addr=0x13 after write 0xA5A5 to 0x10 -> rdata=0xA5A5.
- Reset asserted during BUSY of a read, deasserted 2 cycles later -> no valid pulse; mem_ready=1 immediately on reset; a following read of a previously written word returns its retained value.
